// File: rtl/chimera_cluster_pwr_seq_if.sv
// rtl/chimera_cluster_pwr_seq_if.sv - request/status bundle between register slave, sequencer and clusters
interface chimera_cluster_pwr_seq_if #(
    parameter int unsigned NumClusters = 5
);
    logic [NumClusters-1:0] req_on_i;
    logic [NumClusters-1:0] req_off_i;
    logic [NumClusters-1:0] cluster_busy_i;
    logic [NumClusters-1:0] clu_clk_en_o;
    logic [NumClusters-1:0] clu_rst_no;
    logic [NumClusters-1:0] clu_wake_o;
    logic [NumClusters-1:0] clu_on_o;
    logic                   seq_busy_o;

    modport master (
        output req_on_i, req_off_i, cluster_busy_i,
        input  clu_clk_en_o, clu_rst_no, clu_wake_o, clu_on_o, seq_busy_o
    );

    modport slave (
        input  req_on_i, req_off_i, cluster_busy_i,
        output clu_clk_en_o, clu_rst_no, clu_wake_o, clu_on_o, seq_busy_o
    );
endinterface

// File: rtl/chimera_cluster_pwr_seq.sv
// rtl/chimera_cluster_pwr_seq.sv - round-robin power sequencer for the Snitch clusters
// One cluster at a time: clock on, settle, release reset, wake; or drain, reset, gate clock.
module chimera_cluster_pwr_seq #(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned RstHoldCycles   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    chimera_cluster_pwr_seq_if.slave      io_seq
);
    localparam int unsigned MaxHold = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
    localparam int unsigned CntW    = $clog2(MaxHold + 1);
    localparam int unsigned IdxW    = (NumClusters > 1) ? $clog2(NumClusters) : 1;
    localparam logic [CntW-1:0] CntSettle = CntW'(ClkSettleCycles);
    localparam logic [CntW-1:0] CntHold   = CntW'(RstHoldCycles);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumClusters - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] UP_CLK   = 3'd1;
    localparam logic [2:0] UP_RST   = 3'd2;
    localparam logic [2:0] UP_WAKE  = 3'd3;
    localparam logic [2:0] DN_DRAIN = 3'd4;
    localparam logic [2:0] DN_RST   = 3'd5;
    localparam logic [2:0] DN_CLK   = 3'd6;

    logic [2:0]             r_state, w_state_nxt;
    logic [CntW-1:0]        r_cnt;
    logic [IdxW-1:0]        r_act, r_ptr, w_grant, w_cand;
    logic                   w_grant_vld, w_grant_go, w_grant_up, w_cnt_done;
    logic [NumClusters-1:0] r_pend_on, r_pend_off, w_eligible, w_act_mask;
    logic [NumClusters-1:0] r_clk_en, r_rst_n, r_wake, r_on;
    logic                   r_seq_busy;

    assign w_eligible = r_pend_on | r_pend_off;
    assign w_cnt_done = (r_cnt == CntW'(1));
    assign w_grant_go = w_grant_vld && (r_state == IDLE);
    assign w_grant_up = r_pend_on[w_grant];

    // First eligible index at or above the pointer, wrapping around.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_cand      = '0;
        for (int k = 0; k < int'(NumClusters); k++) begin
            w_cand = IdxW'((int'(r_ptr) + k) % int'(NumClusters));
            if (!w_grant_vld && w_eligible[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_cand;
            end
        end
    end

    // The cluster being granted this cycle is already treated as active.
    always_comb begin
        w_act_mask = '0;
        if (r_state != IDLE)
            w_act_mask[r_act] = 1'b1;
        else if (w_grant_go)
            w_act_mask[w_grant] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_grant_go) w_state_nxt = w_grant_up ? UP_CLK : DN_DRAIN;
            UP_CLK:   if (w_cnt_done) w_state_nxt = UP_RST;
            UP_RST:   if (w_cnt_done) w_state_nxt = UP_WAKE;
            UP_WAKE:  w_state_nxt = IDLE;
            DN_DRAIN: if (!io_seq.cluster_busy_i[r_act]) w_state_nxt = DN_RST;
            DN_RST:   if (w_cnt_done) w_state_nxt = DN_CLK;
            DN_CLK:   w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_act      <= '0;
            r_ptr      <= '0;
            r_pend_on  <= '0;
            r_pend_off <= '0;
            r_clk_en   <= '0;
            r_rst_n    <= '0;
            r_wake     <= '0;
            r_on       <= '0;
            r_seq_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seq_busy <= (w_state_nxt != IDLE);
            r_wake     <= '0;
            if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            for (int i = 0; i < int'(NumClusters); i++) begin
                if (!w_act_mask[i]) begin
                    if (io_seq.req_on_i[i] && !r_on[i])
                        r_pend_on[i] <= 1'b1;
                    else if (io_seq.req_off_i[i] && r_on[i])
                        r_pend_off[i] <= 1'b1;
                end
            end
            case (r_state)
                IDLE: if (w_grant_go) begin
                    r_act               <= w_grant;
                    r_ptr               <= (w_grant == LastIdx) ? '0 : w_grant + 1'b1;
                    r_pend_on[w_grant]  <= 1'b0;
                    r_pend_off[w_grant] <= 1'b0;
                    if (w_grant_up) begin
                        r_clk_en[w_grant] <= 1'b1;
                        r_cnt             <= CntSettle;
                    end
                end
                UP_CLK: if (w_cnt_done) begin
                    r_rst_n[r_act] <= 1'b1;
                    r_cnt          <= CntHold;
                end
                UP_RST:  if (w_cnt_done) r_wake[r_act] <= 1'b1;
                UP_WAKE: r_on[r_act] <= 1'b1;
                // Reset is asserted with the clock still running so the cluster resets cleanly.
                DN_DRAIN: if (!io_seq.cluster_busy_i[r_act]) begin
                    r_rst_n[r_act] <= 1'b0;
                    r_cnt          <= CntHold;
                end
                DN_RST: if (w_cnt_done) begin
                    r_clk_en[r_act] <= 1'b0;
                    r_on[r_act]     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign io_seq.clu_clk_en_o = r_clk_en;
    assign io_seq.clu_rst_no   = r_rst_n;
    assign io_seq.clu_wake_o   = r_wake;
    assign io_seq.clu_on_o     = r_on;
    assign io_seq.seq_busy_o   = r_seq_busy;
endmodule
